// File: rtl/rr_mux_reg.sv
// N-channel selector with registered output stage and valid/ready handshakes.
// Round-robin arbitration by default; forced mode routes one chosen channel.
module rr_mux_reg #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NCH-1:0]       i_in_valid,
    input  logic [NCH*WIDTH-1:0] i_in_data,
    output logic [NCH-1:0]       o_in_ready,
    input  logic                 i_force_en,
    input  logic [SELW-1:0]      i_force_sel,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [WIDTH-1:0]     o_out_data,
    output logic [SELW-1:0]      o_out_sel
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e            r_state, w_state_nxt;
    logic [SELW-1:0]   r_ptr, w_ptr_nxt;
    logic [SELW-1:0]   r_sel, w_sel_nxt;
    logic [WIDTH-1:0]  r_data, w_data_nxt;
    logic [SELW-1:0]   w_gnt;
    logic [WIDTH-1:0]  w_gnt_data;
    logic              w_found;
    logic              w_load_ok;
    logic              w_xfer;

    // Grant: forced select (out-of-range indices never match) or RR scan from r_ptr+1.
    always_comb begin
        int unsigned idx;
        w_found = 1'b0;
        w_gnt   = '0;
        idx     = 0;
        if (i_force_en) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (i_force_sel == SELW'(i) && i_in_valid[i]) begin
                    w_found = 1'b1;
                    w_gnt   = SELW'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= NCH; k++) begin
                idx = 32'(r_ptr) + k;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (!w_found && idx == i && i_in_valid[i]) begin
                        w_found = 1'b1;
                        w_gnt   = SELW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        w_gnt_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_gnt == SELW'(i)) begin
                w_gnt_data = i_in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_load_ok = (r_state == StEmpty) || i_out_ready;
    // No transfer can happen in a reset cycle, so no channel is told it was taken.
    assign w_xfer    = !i_rst && w_load_ok && w_found;

    always_comb begin
        o_in_ready = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            o_in_ready[i] = w_xfer && (w_gnt == SELW'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_data_nxt  = r_data;
        if (w_load_ok) begin
            if (w_found) begin
                w_state_nxt = StFull;
                w_sel_nxt   = w_gnt;
                w_data_nxt  = w_gnt_data;
                if (!i_force_en) begin
                    w_ptr_nxt = w_gnt;
                end
            end else begin
                w_state_nxt = StEmpty;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StEmpty;
            r_ptr   <= SELW'(NCH - 1);
            r_sel   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign o_out_valid = (r_state == StFull);
    assign o_out_data  = r_data;
    assign o_out_sel   = r_sel;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Self-checking bench for rr_mux_reg: a 4-channel instance with a reference model
// and scoreboard, plus a 3-channel instance for illegal forced selects.
module tb_rr_mux_reg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  in_valid;
    logic [2:0]  data4 [4];
    logic [11:0] in_data;
    logic [3:0]  in_ready;
    logic        force_en;
    logic [1:0]  force_sel;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_data;
    logic [1:0]  out_sel;

    logic [2:0]  in_valid3;
    logic [8:0]  in_data3;
    logic [2:0]  in_ready3;
    logic        force_en3;
    logic [1:0]  force_sel3;
    logic        out_valid3;
    logic        out_ready3;
    logic [2:0]  out_data3;
    logic [1:0]  out_sel3;

    assign in_data = {data4[3], data4[2], data4[1], data4[0]};

    rr_mux_reg #(.WIDTH(3), .NCH(4), .SELW(2)) u_dut4 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .i_force_en  (force_en),
        .i_force_sel (force_sel),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_sel   (out_sel)
    );

    rr_mux_reg #(.WIDTH(3), .NCH(3), .SELW(2)) u_dut3 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid3),
        .i_in_data   (in_data3),
        .o_in_ready  (in_ready3),
        .i_force_en  (force_en3),
        .i_force_sel (force_sel3),
        .o_out_valid (out_valid3),
        .i_out_ready (out_ready3),
        .o_out_data  (out_data3),
        .o_out_sel   (out_sel3)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic [2:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] m_ptr;
    bit         m_full;
    logic [1:0] m_sel;
    logic [2:0] m_data;

    // Reference grant for the 4-channel instance.
    function automatic bit model_grant(input logic [3:0] v, input logic fe, input logic [1:0] fs,
                                       input logic [1:0] ptr, output logic [1:0] g);
        g = 2'd0;
        if (fe) begin
            g = fs;
            return v[fs];
        end
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] c;
            c = ptr + 2'(k);
            if (v[c]) begin
                g = c;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // One clock of the 4-channel instance: predict, push, advance, pop, update model.
    task automatic step(output logic [3:0] rdy_act, output logic [3:0] rdy_exp);
        logic [1:0] g;
        bit         found;
        bit         lok;
        exp_t       t;
        @(negedge clk);
        rdy_act = in_ready;
        found   = model_grant(in_valid, force_en, force_sel, m_ptr, g);
        lok     = !m_full || out_ready;
        rdy_exp = 4'b0;
        if (lok && found) begin
            rdy_exp[g] = 1'b1;
            t.sel      = g;
            t.data     = data4[g];
            sb.push_back(t);
        end
        @(posedge clk);
        #1;
        if (lok && found) begin
            t      = sb.pop_front();
            m_full = 1'b1;
            m_sel  = t.sel;
            m_data = t.data;
            if (!force_en) m_ptr = t.sel;
        end else if (lok) begin
            m_full = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_ptr  = 2'd3;
        m_full = 1'b0;
        m_sel  = 2'd0;
        m_data = 3'd0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 4'hF;
        force_en   = 1'b0;
        force_sel  = 2'd0;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) data4[i] = 3'(i + 1);
        in_valid3  = 3'b111;
        in_data3   = {3'd3, 3'd2, 3'd1};
        force_en3  = 1'b0;
        force_sel3 = 2'd0;
        out_ready3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 4'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 3'd0 || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%0d s=%0d want v=0 d=0 s=0",
                     out_valid, out_data, out_sel);
        end
        n_checks++;
        if (in_ready3 !== 3'b0 || out_valid3 !== 1'b0) begin
            n_fail++; $display("FAIL reset_dut3: got rdy=%b v=%b want 000 0", in_ready3, out_valid3);
        end
        in_valid  = 4'h0;
        in_valid3 = 3'b000;
        rst       = 1'b0;
        model_reset();
    endtask

    task automatic test_rr_fairness();
        logic [3:0] ra, re;
        logic [1:0] exp_sel [5];
        exp_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        @(posedge clk);
        #1;
        in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step(ra, re);
            n_checks++;
            if (ra !== re) begin
                n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", i, ra, re);
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== m_sel || out_data !== m_data) begin
                n_fail++;
                $display("FAIL rr_model[%0d]: got v=%b s=%0d d=%0d want v=1 s=%0d d=%0d",
                         i, out_valid, out_sel, out_data, m_sel, m_data);
            end
            n_checks++;
            if (out_sel !== exp_sel[i] || out_data !== 3'(exp_sel[i] + 2'd1)) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: got s=%0d d=%0d want s=%0d d=%0d",
                         i, out_sel, out_data, exp_sel[i], exp_sel[i] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] ra, re;
        data4[2] = 3'b101;
        in_valid = 4'b0100;
        step(ra, re);
        n_checks++;
        if (ra !== 4'b0100 || out_sel !== 2'd2 || out_data !== 3'd5) begin
            n_fail++;
            $display("FAIL bp_load: got rdy=%b s=%0d d=%0d want 0100 s=2 d=5", ra, out_sel, out_data);
        end
        out_ready = 1'b0;
        in_valid  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step(ra, re);
            n_checks++;
            if (ra !== 4'b0 || ra !== re) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, ra);
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 3'd5 || out_sel !== 2'd2) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%0d s=%0d want v=1 d=5 s=2",
                         i, out_valid, out_data, out_sel);
            end
        end
        out_ready = 1'b1;
        step(ra, re);
        n_checks++;
        if (ra !== re || out_sel !== 2'd3 || out_sel !== m_sel || out_data !== m_data) begin
            n_fail++;
            $display("FAIL bp_release: got rdy=%b s=%0d want rdy=%b s=3", ra, out_sel, re);
        end
        data4[2] = 3'd3;
    endtask

    task automatic test_forced();
        logic [3:0] ra, re;
        force_en  = 1'b1;
        force_sel = 2'd2;
        in_valid  = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            step(ra, re);
            n_checks++;
            if (ra !== 4'b0100 || ra !== re) begin
                n_fail++; $display("FAIL force_ready[%0d]: got %b want 0100", i, ra);
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 3'd3) begin
                n_fail++;
                $display("FAIL force_out[%0d]: got v=%b s=%0d d=%0d want v=1 s=2 d=3",
                         i, out_valid, out_sel, out_data);
            end
        end
        force_en = 1'b0;
        step(ra, re);
        n_checks++;
        if (ra !== 4'b0001 || out_sel !== 2'd0 || out_data !== 3'd1 || out_sel !== m_sel) begin
            n_fail++;
            $display("FAIL force_exit: got rdy=%b s=%0d d=%0d want 0001 s=0 d=1", ra, out_sel, out_data);
        end
    endtask

    task automatic test_illegal_empty();
        logic [3:0] ra, re;
        in_valid = 4'h0;
        step(ra, re);
        n_checks++;
        if (ra !== 4'b0 || out_valid !== 1'b0 || out_data !== m_data || out_sel !== m_sel) begin
            n_fail++;
            $display("FAIL empty4: got rdy=%b v=%b d=%0d want 0000 v=0 d=%0d", ra, out_valid, out_data,
                     m_data);
        end
        in_valid3 = 3'b111;
        force_en3 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready3 !== 3'b001) begin
            n_fail++; $display("FAIL n3_rr_ready: got %b want 001", in_ready3);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid3 !== 1'b1 || out_sel3 !== 2'd0 || out_data3 !== 3'd1) begin
            n_fail++;
            $display("FAIL n3_rr_out: got v=%b s=%0d d=%0d want v=1 s=0 d=1", out_valid3, out_sel3,
                     out_data3);
        end
        force_en3  = 1'b1;
        force_sel3 = 2'd3;
        @(negedge clk);
        n_checks++;
        if (in_ready3 !== 3'b000) begin
            n_fail++; $display("FAIL n3_illegal_ready: got %b want 000", in_ready3);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid3 !== 1'b0 || out_data3 !== 3'd1 || out_sel3 !== 2'd0) begin
            n_fail++;
            $display("FAIL n3_illegal_out: got v=%b d=%0d s=%0d want v=0 d=1 s=0", out_valid3,
                     out_data3, out_sel3);
        end
        force_sel3 = 2'd2;
        @(negedge clk);
        n_checks++;
        if (in_ready3 !== 3'b100) begin
            n_fail++; $display("FAIL n3_force2_ready: got %b want 100", in_ready3);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid3 !== 1'b1 || out_sel3 !== 2'd2 || out_data3 !== 3'd3) begin
            n_fail++;
            $display("FAIL n3_force2_out: got v=%b s=%0d d=%0d want v=1 s=2 d=3", out_valid3,
                     out_sel3, out_data3);
        end
        force_en3 = 1'b0;
        in_valid3 = 3'b000;
        @(negedge clk);
        n_checks++;
        if (in_ready3 !== 3'b000) begin
            n_fail++; $display("FAIL n3_empty_ready: got %b want 000", in_ready3);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid3 !== 1'b0 || out_data3 !== 3'd3) begin
            n_fail++;
            $display("FAIL n3_empty_out: got v=%b d=%0d want v=0 d=3", out_valid3, out_data3);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ra, re;
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        step(ra, re);
        n_checks++;
        if (ra !== re || out_sel !== 2'd1 || out_data !== 3'd2) begin
            n_fail++; $display("FAIL mid_load: got rdy=%b s=%0d d=%0d want 0010 s=1 d=2", ra, out_sel,
                               out_data);
        end
        out_ready = 1'b0;
        in_valid  = 4'hF;
        step(ra, re);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 4'b0) begin
            n_fail++; $display("FAIL mid_rst_ready: got %b want 0000", in_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 3'd0 || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_rst_out: got v=%b d=%0d s=%0d want v=0 d=0 s=0", out_valid, out_data,
                     out_sel);
        end
        model_reset();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(ra, re);
            n_checks++;
            if (ra !== re || out_sel !== m_sel || out_data !== m_data || out_sel !== 2'(i)) begin
                n_fail++;
                $display("FAIL mid_after[%0d]: got rdy=%b s=%0d d=%0d want rdy=%b s=%0d", i, ra,
                         out_sel, out_data, re, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_backpressure();
        test_forced();
        test_illegal_empty();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
